// File: rtl/spike_fifo_dispatcher.sv
// rtl/spike_fifo_dispatcher.sv - spike-index FIFO reader, frame parser and spike dispatcher
//
// Reads neuron indices from a spike-index FIFO. The marker word F1FA opens a
// timestep frame and FAF1 closes it. Each in-range index inside a frame is
// handed to the downstream PE with a valid/ready handshake.
//
// Build option: SPIKE_CNT_EN - builds the per-frame spike counter that drives
// ts_spike_num. When it is undefined, ts_spike_num is tied to zero.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   empty        in   FIFO empty
//   r_en         out  FIFO read strobe (data arrives the following cycle)
//   r_data       in   FIFO word
//   spike_addr   out  dispatched neuron index
//   spike_valid  out  spike_addr valid
//   spike_ready  in   downstream accepts the spike
//   in_frame     out  between F1FA and FAF1
//   ts_start     out  one-cycle pulse on F1FA
//   ts_done      out  one-cycle pulse on FAF1
//   ts_cnt       out  completed timesteps (wrapping)
//   oor_err      out  one-cycle pulse when an out-of-range index is dropped
//   frame_err    out  one-cycle pulse when F1FA arrives inside a frame
//   ts_spike_num out  spikes emitted in the last completed frame
module spike_fifo_dispatcher #(
    parameter int NEURON_NUM = 1024,
    parameter int TS_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            empty,
    output logic            r_en,
    input  logic [15:0]     r_data,
    output logic [15:0]     spike_addr,
    output logic            spike_valid,
    input  logic            spike_ready,
    output logic            in_frame,
    output logic            ts_start,
    output logic            ts_done,
    output logic [TS_W-1:0] ts_cnt,
    output logic            oor_err,
    output logic            frame_err,
    output logic [15:0]     ts_spike_num
);

    localparam logic [1:0] S_HUNT = 2'd0;
    localparam logic [1:0] S_BODY = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;

    localparam logic [15:0] W_START = 16'hF1FA;
    localparam logic [15:0] W_END   = 16'hFAF1;

    // One extra bit so NEURON_NUM = 65536 still compares correctly.
    localparam logic [16:0] ADDR_LIM = 17'(NEURON_NUM);

    logic [1:0]      state_q, state_d;
    logic            pend_q, pend_d;
    logic [15:0]     addr_q, addr_d;
    logic            valid_q, valid_d;
    logic            in_frame_q, in_frame_d;
    logic            start_q, start_d;
    logic            done_q, done_d;
    logic            oor_q, oor_d;
    logic            ferr_q, ferr_d;
    logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;

    // Frame spike counter controls
    logic cnt_clr;
    logic cnt_inc;
    logic cnt_latch;

    // New reads only while parsing and only when the previous word has been
    // consumed; the rst term keeps the strobe low during the reset cycle.
    assign r_en = !rst && !empty && !pend_q &&
                  ((state_q == S_HUNT) || (state_q == S_BODY));

    always_comb begin
        state_d    = state_q;
        pend_d     = r_en;
        addr_d     = addr_q;
        valid_d    = valid_q;
        in_frame_d = in_frame_q;
        start_d    = 1'b0;
        done_d     = 1'b0;
        oor_d      = 1'b0;
        ferr_d     = 1'b0;
        ts_cnt_d   = ts_cnt_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        cnt_latch  = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (pend_q && (r_data == W_START)) begin
                    start_d    = 1'b1;
                    in_frame_d = 1'b1;
                    cnt_clr    = 1'b1;
                    state_d    = S_BODY;
                end
            end
            S_BODY: begin
                if (pend_q) begin
                    if (r_data == W_END) begin
                        done_d     = 1'b1;
                        ts_cnt_d   = ts_cnt_q + TS_W'(1);
                        cnt_latch  = 1'b1;
                        in_frame_d = 1'b0;
                        state_d    = S_HUNT;
                    end else if (r_data == W_START) begin
                        // Restart the frame in place; the partial frame is abandoned.
                        ferr_d  = 1'b1;
                        start_d = 1'b1;
                        cnt_clr = 1'b1;
                    end else if ({1'b0, r_data} < ADDR_LIM) begin
                        addr_d  = r_data;
                        valid_d = 1'b1;
                        state_d = S_EMIT;
                    end else begin
                        oor_d = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (valid_q && spike_ready) begin
                    valid_d = 1'b0;
                    cnt_inc = 1'b1;
                    state_d = S_BODY;
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HUNT;
            pend_q     <= 1'b0;
            addr_q     <= 16'h0;
            valid_q    <= 1'b0;
            in_frame_q <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            oor_q      <= 1'b0;
            ferr_q     <= 1'b0;
            ts_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            in_frame_q <= in_frame_d;
            start_q    <= start_d;
            done_q     <= done_d;
            oor_q      <= oor_d;
            ferr_q     <= ferr_d;
            ts_cnt_q   <= ts_cnt_d;
        end
    end

`ifdef SPIKE_CNT_EN
    logic [15:0] spk_cnt_q, spk_cnt_d;
    logic [15:0] spk_num_q, spk_num_d;

    always_comb begin
        spk_cnt_d = spk_cnt_q;
        spk_num_d = spk_num_q;
        if (cnt_clr) begin
            spk_cnt_d = 16'h0;
        end else if (cnt_inc && (spk_cnt_q != 16'hFFFF)) begin
            spk_cnt_d = spk_cnt_q + 16'h1;
        end
        if (cnt_latch) begin
            spk_num_d = spk_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spk_cnt_q <= 16'h0;
            spk_num_q <= 16'h0;
        end else begin
            spk_cnt_q <= spk_cnt_d;
            spk_num_q <= spk_num_d;
        end
    end

    assign ts_spike_num = spk_num_q;
`else
    logic unused_cnt_ctrl;
    assign unused_cnt_ctrl = cnt_clr ^ cnt_inc ^ cnt_latch;
    assign ts_spike_num    = 16'h0;
`endif

    assign spike_addr  = addr_q;
    assign spike_valid = valid_q;
    assign in_frame    = in_frame_q;
    assign ts_start    = start_q;
    assign ts_done     = done_q;
    assign ts_cnt      = ts_cnt_q;
    assign oor_err     = oor_q;
    assign frame_err   = ferr_q;

endmodule

// File: tb/tb_spike_fifo_dispatcher.sv
// tb/tb_spike_fifo_dispatcher.sv - directed self-checking bench for spike_fifo_dispatcher
module tb_spike_fifo_dispatcher;

`ifdef SPIKE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        empty = 1'b1;
    logic        r_en;
    logic [15:0] r_data = 16'h0;
    logic [15:0] spike_addr;
    logic        spike_valid;
    logic        spike_ready = 1'b0;
    logic        in_frame;
    logic        ts_start;
    logic        ts_done;
    logic [7:0]  ts_cnt;
    logic        oor_err;
    logic        frame_err;
    logic [15:0] ts_spike_num;

    int tests = 0;
    int fails = 0;

    logic [15:0] fifo[$];
    logic [15:0] got[$];
    int          n_start, n_done, n_oor, n_ferr, rviol;
    logic        r_en_prev = 1'b0;

    spike_fifo_dispatcher #(.NEURON_NUM(1024), .TS_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .empty        (empty),
        .r_en         (r_en),
        .r_data       (r_data),
        .spike_addr   (spike_addr),
        .spike_valid  (spike_valid),
        .spike_ready  (spike_ready),
        .in_frame     (in_frame),
        .ts_start     (ts_start),
        .ts_done      (ts_done),
        .ts_cnt       (ts_cnt),
        .oor_err      (oor_err),
        .frame_err    (frame_err),
        .ts_spike_num (ts_spike_num)
    );

    always #5 clk = ~clk;

    // FIFO model: word appears on r_data the cycle after r_en
    always @(posedge clk) begin
        if (r_en && fifo.size() != 0) r_data <= fifo.pop_front();
    end

    always @(negedge clk) begin
        empty <= (fifo.size() == 0);
    end

    // Event monitor sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (ts_start) n_start++;
            if (ts_done) n_done++;
            if (oor_err) n_oor++;
            if (frame_err) n_ferr++;
            if (spike_valid && spike_ready) got.push_back(spike_addr);
            if (r_en && r_en_prev) rviol++;
        end
        r_en_prev = r_en;
    end

    task automatic clear_mon();
        n_start = 0; n_done = 0; n_oor = 0; n_ferr = 0;
        got.delete();
    endtask

    task automatic do_reset();
        fifo.delete();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        fifo.push_back(w);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40 && !spike_valid; i++) @(negedge clk);
        tests++;
        if (spike_valid !== 1'b1) begin
            fails++;
            $display("FAIL wait_valid: spike_valid=%b, required 1 within 40 cycles", spike_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; spike_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (r_en !== 1'b0 || spike_valid !== 1'b0 || spike_addr !== 16'h0 || in_frame !== 1'b0) begin
            fails++;
            $display("FAIL reset_a: r_en=%b valid=%b addr=%h in_frame=%b, required all 0",
                     r_en, spike_valid, spike_addr, in_frame);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (ts_start !== 1'b0 || ts_done !== 1'b0 || oor_err !== 1'b0 || frame_err !== 1'b0 ||
            ts_cnt !== 8'h0 || ts_spike_num !== 16'h0) begin
            fails++;
            $display("FAIL reset_b: start=%b done=%b oor=%b ferr=%b ts_cnt=%h num=%h, required all 0",
                     ts_start, ts_done, oor_err, frame_err, ts_cnt, ts_spike_num);
        end
        clear_mon();
    endtask

    task automatic test_basic();
        do_reset();
        spike_ready = 1'b1;
        push(16'hF1FA); push(16'h0005); push(16'h0010); push(16'hFAF1);
        wait_cycles(20);
        tests++;
        if (n_start != 1 || n_done != 1) begin
            fails++;
            $display("FAIL basic_pulses: start=%0d done=%0d, required 1 1", n_start, n_done);
        end
        tests++;
        if (got.size() != 2 || got[0] !== 16'h0005 || got[1] !== 16'h0010) begin
            fails++;
            $display("FAIL basic_spikes: count=%0d, required 2 spikes 0005 0010", got.size());
        end
        tests++;
        if (ts_cnt !== 8'd1 || ts_spike_num !== (CNT_ON ? 16'd2 : 16'd0) || in_frame !== 1'b0) begin
            fails++;
            $display("FAIL basic_counts: ts_cnt=%0d num=%0d in_frame=%b, required 1 %0d 0",
                     ts_cnt, ts_spike_num, in_frame, CNT_ON ? 2 : 0);
        end
    endtask

    task automatic test_discard();
        do_reset();
        spike_ready = 1'b1;
        push(16'h1234); push(16'hF1FA); push(16'hFAF1);
        wait_cycles(16);
        tests++;
        if (n_oor != 0 || n_ferr != 0 || got.size() != 0) begin
            fails++;
            $display("FAIL discard_err: oor=%0d ferr=%0d spikes=%0d, required 0 0 0",
                     n_oor, n_ferr, got.size());
        end
        tests++;
        if (ts_cnt !== 8'd1 || ts_spike_num !== 16'd0) begin
            fails++;
            $display("FAIL discard_counts: ts_cnt=%0d num=%0d, required 1 0", ts_cnt, ts_spike_num);
        end
    endtask

    task automatic test_oor();
        do_reset();
        spike_ready = 1'b1;
        push(16'hF1FA); push(16'h0400); push(16'h03FF); push(16'hFAF1);
        wait_cycles(20);
        tests++;
        if (n_oor != 1) begin
            fails++;
            $display("FAIL oor_pulse: count=%0d, required 1", n_oor);
        end
        tests++;
        if (got.size() != 1 || got[0] !== 16'h03FF) begin
            fails++;
            $display("FAIL oor_spikes: count=%0d, required 1 spike 03FF", got.size());
        end
        tests++;
        if (ts_spike_num !== (CNT_ON ? 16'd1 : 16'd0)) begin
            fails++;
            $display("FAIL oor_num: num=%0d, required %0d", ts_spike_num, CNT_ON ? 1 : 0);
        end
    endtask

    task automatic test_hold();
        int bad;
        do_reset();
        spike_ready = 1'b0;
        push(16'hF1FA); push(16'h0007); push(16'hFAF1);
        wait_valid();
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (spike_valid !== 1'b1 || spike_addr !== 16'h0007 || r_en !== 1'b0) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_stable: %0d bad cycles, required 0", bad);
        end
        #1 spike_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (spike_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold_accept: spike_valid=%b, required 0", spike_valid);
        end
        wait_cycles(10);
        tests++;
        if (n_done != 1 || ts_spike_num !== (CNT_ON ? 16'd1 : 16'd0)) begin
            fails++;
            $display("FAIL hold_done: done=%0d num=%0d, required 1 %0d",
                     n_done, ts_spike_num, CNT_ON ? 1 : 0);
        end
    endtask

    task automatic test_frame_err();
        do_reset();
        spike_ready = 1'b1;
        push(16'hF1FA); push(16'h0001); push(16'hF1FA); push(16'h0002); push(16'hFAF1);
        wait_cycles(24);
        tests++;
        if (n_ferr != 1 || n_start != 2) begin
            fails++;
            $display("FAIL ferr_pulses: ferr=%0d start=%0d, required 1 2", n_ferr, n_start);
        end
        tests++;
        if (got.size() != 2 || ts_spike_num !== (CNT_ON ? 16'd1 : 16'd0) || ts_cnt !== 8'd1) begin
            fails++;
            $display("FAIL ferr_counts: spikes=%0d num=%0d ts_cnt=%0d, required 2 %0d 1",
                     got.size(), ts_spike_num, ts_cnt, CNT_ON ? 1 : 0);
        end
    endtask

    // Runs straight after test_frame_err, so ts_cnt is 1 on entry
    task automatic test_reset_emit();
        spike_ready = 1'b0;
        push(16'hF1FA); push(16'h0009); push(16'hFAF1);
        wait_valid();
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (spike_valid !== 1'b0 || spike_addr !== 16'h0 || in_frame !== 1'b0 ||
            ts_cnt !== 8'h0 || r_en !== 1'b0 || ts_spike_num !== 16'h0) begin
            fails++;
            $display("FAIL rst_emit: valid=%b addr=%h in_frame=%b ts_cnt=%0d r_en=%b num=%0d, required all 0",
                     spike_valid, spike_addr, in_frame, ts_cnt, r_en, ts_spike_num);
        end
        rst = 1'b0;
        clear_mon();
        wait_cycles(10);
        tests++;
        if (in_frame !== 1'b0 || n_done != 0 || ts_cnt !== 8'd0) begin
            fails++;
            $display("FAIL rst_emit_hunt: in_frame=%b done=%0d ts_cnt=%0d, required 0 0 0",
                     in_frame, n_done, ts_cnt);
        end
        spike_ready = 1'b1;
        push(16'hF1FA); push(16'hFAF1);
        wait_cycles(12);
        tests++;
        if (ts_cnt !== 8'd1 || n_done != 1 || n_start != 1) begin
            fails++;
            $display("FAIL rst_emit_frame: ts_cnt=%0d done=%0d start=%0d, required 1 1 1",
                     ts_cnt, n_done, n_start);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        spike_ready = 1'b1;
        for (int f = 0; f < 255; f++) begin
            push(16'hF1FA); push(16'hFAF1);
        end
        wait_cycles(1040);
        tests++;
        if (ts_cnt !== 8'd255 || n_done != 255) begin
            fails++;
            $display("FAIL wrap_255: ts_cnt=%0d done=%0d, required 255 255", ts_cnt, n_done);
        end
        push(16'hF1FA); push(16'hFAF1);
        wait_cycles(12);
        tests++;
        if (ts_cnt !== 8'd0 || n_done != 256) begin
            fails++;
            $display("FAIL wrap_256: ts_cnt=%0d done=%0d, required 0 256", ts_cnt, n_done);
        end
    endtask

    initial begin
        rviol = 0;
        clear_mon();
        test_reset();
        test_basic();
        test_discard();
        test_oor();
        test_hold();
        test_frame_err();
        test_reset_emit();
        test_wrap();
        tests++;
        if (rviol != 0) begin
            fails++;
            $display("FAIL read_spacing: %0d back-to-back r_en cycles, required 0", rviol);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
